// File: rtl/mem_pkg.sv
// Shared data-memory types: access width encoding, address type and the
// load/store aligner state set, plus small size/alignment helpers.
package mem_pkg;

  typedef logic [9:0] DMemAddrT;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } mem_width_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGNED,
    RD_LO,
    RD_HI,
    WR_BYTE,
    RESP
  } lsu_state_t;

  function automatic logic [2:0] width_bytes(input mem_width_t w);
    case (w)
      BYTE:     return 3'd1;
      HALFWORD: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  // An access is naturally aligned when its offset is a multiple of its size.
  function automatic logic is_aligned(input logic [1:0] off, input mem_width_t w);
    case (w)
      BYTE:     return 1'b1;
      HALFWORD: return ~off[0];
      default:  return off == 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_merge.sv
// Combines two consecutive aligned words into the bytes of one misaligned
// load, then zero- or sign-extends the result to 32 bits.
module lsu_align_merge
  import mem_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  off,
  input  mem_width_t  width,
  input  logic        sign_extend,
  output logic [31:0] data
);

  logic [31:0] window;

  always_comb begin
    window = 32'({hi, lo} >> {off, 3'b000});
    case (width)
      BYTE:     data = {{24{sign_extend & window[7]}}, window[7:0]};
      HALFWORD: data = {{16{sign_extend & window[15]}}, window[15:0]};
      default:  data = window;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store initiator in front of the data SRAM: aligned accesses pass
// through, misaligned loads use two word reads, misaligned stores use byte writes.
module lsu_align
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = $bits(DMemAddrT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  mem_width_t            req_width,
  input  logic                  req_sign_extend,
  input  logic                  req_write,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output DMemAddrT              mem_addr,
  output mem_width_t            mem_width,
  output logic                  mem_sign_extend,
  output logic                  mem_write_enable,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out
);

  lsu_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  mem_width_t            width_q;
  logic                  sign_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic                  split_q;
  logic [1:0]            k_q;
  logic [31:0]           lo_q;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  mem_width_t            mem_width_q;
  logic                  mem_sign_q;
  logic                  mem_we_q;
  logic [31:0]           mem_din_q;

  logic [1:0]            k_next;
  logic [31:0]           merged;

  assign k_next = k_q + 2'd1;

  lsu_align_merge u_merge (
    .lo          (lo_q),
    .hi          (mem_data_out),
    .off         (addr_q[1:0]),
    .width       (width_q),
    .sign_extend (sign_q),
    .data        (merged)
  );

  // Memory-side controls are registered on the edge entering each state so
  // they are stable for the whole cycle the SRAM samples them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      width_q     <= WORD;
      sign_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      split_q     <= 1'b0;
      k_q         <= '0;
      lo_q        <= '0;
      mem_addr_q  <= '0;
      mem_width_q <= WORD;
      mem_sign_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_din_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            width_q <= req_width;
            sign_q  <= req_sign_extend;
            write_q <= req_write;
            wdata_q <= req_wdata;
            split_q <= ~is_aligned(req_addr[1:0], req_width);
            k_q     <= '0;
            if (is_aligned(req_addr[1:0], req_width)) begin
              state       <= ALIGNED;
              mem_addr_q  <= req_addr;
              mem_width_q <= req_width;
              mem_sign_q  <= req_sign_extend;
              mem_we_q    <= req_write;
              mem_din_q   <= req_wdata;
            end else if (!req_write) begin
              state       <= RD_LO;
              mem_addr_q  <= req_addr & ~ADDR_WIDTH'(3);
              mem_width_q <= WORD;
              mem_sign_q  <= 1'b0;
              mem_we_q    <= 1'b0;
            end else begin
              state       <= WR_BYTE;
              mem_addr_q  <= req_addr;
              mem_width_q <= BYTE;
              mem_sign_q  <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_din_q   <= {24'b0, req_wdata[7:0]};
            end
          end
        end
        ALIGNED: begin
          mem_we_q <= 1'b0;
          state    <= RESP;
        end
        RD_LO: begin
          mem_addr_q <= {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
          state      <= RD_HI;
        end
        RD_HI: begin
          lo_q  <= mem_data_out;
          state <= RESP;
        end
        WR_BYTE: begin
          if ({1'b0, k_q} == width_bytes(width_q) - 3'd1) begin
            mem_we_q <= 1'b0;
            state    <= RESP;
          end else begin
            k_q        <= k_next;
            mem_addr_q <= addr_q + ADDR_WIDTH'(k_next);
            mem_din_q  <= {24'b0, wdata_q[{k_next, 3'b000} +: 8]};
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset masks the outward controls immediately so an abandoned store
  // cannot write during the reset cycle itself.
  assign req_ready        = (state == IDLE) && !reset;
  assign rsp_valid        = (state == RESP) && !reset;
  assign mem_write_enable = mem_we_q && !reset;
  assign mem_addr         = reset ? '0 : DMemAddrT'(mem_addr_q);
  assign mem_width        = reset ? WORD : mem_width_q;
  assign mem_sign_extend  = mem_sign_q && !reset;
  assign mem_data_in      = reset ? '0 : mem_din_q;

  always_comb begin
    rsp_rdata = '0;
    if (state == RESP && !write_q)
      rsp_rdata = split_q ? merged : mem_data_out;
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store initiator that sits between the pipeline's memory stage and `d_mem_spram`.
- Naturally aligned accesses pass straight through as a single memory transaction.
- Misaligned reads become two aligned word reads, merged and extended locally.
- Misaligned writes become a sequence of byte writes.
- Presents a valid/ready request port upstream and a single-cycle response pulse.

Parameters:
- ADDR_WIDTH, default $bits(DMemAddrT): memory byte-address width; address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_WIDTH  byte address
- req_width  in  mem_width_t  BYTE/HALFWORD/WORD
- req_sign_extend  in  1  sign-extend load result
- req_write  in  1  1=store, 0=load
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle completion pulse (load data or store ack)
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores
- mem_addr  out  DMemAddrT  to d_mem addr
- mem_width  out  mem_width_t  to d_mem width
- mem_sign_extend  out  1  to d_mem sign_extend
- mem_write_enable  out  1  to d_mem write_enable
- mem_data_in  out  32  to d_mem data_in
- mem_data_out  in  32  from d_mem data_out; 1-cycle synchronous read latency

Behaviour:
- Reset:
  - State goes to IDLE.
  - While reset is high: req_ready=0, rsp_valid=0, mem_write_enable=0 (forced combinationally), mem_addr=0, mem_width=WORD, mem_sign_extend=0, mem_data_in=0.
  - Reset mid-operation abandons the transaction; no further memory writes are issued and no response is given.
- Size and alignment:
  - size = 1/2/4 for BYTE/HALFWORD/WORD; off = addr[1:0].
  - Aligned iff off % size == 0. BYTE is always aligned.
- States: IDLE, ALIGNED, RD_LO, RD_HI, WR_BYTE, RESP.
- IDLE:
  - req_ready=1.
  - Handshake at an edge with req_valid=1 latches addr/width/sign/write/wdata.
  - Next state: ALIGNED if aligned; RD_LO if misaligned load; WR_BYTE if misaligned store with byte counter k=0.
- ALIGNED (1 cycle):
  - mem_addr=addr, mem_width=width, mem_sign_extend=sign, mem_write_enable=write, mem_data_in=wdata.
  - Next state: RESP.
  - On a load, RESP drives rsp_rdata=mem_data_out directly.
- RD_LO:
  - mem_addr = addr & ~3, WORD, mem_sign_extend=0.
  - Next state: RD_HI.
- RD_HI:
  - mem_addr = ((addr & ~3) + 4) mod 2^ADDR_WIDTH, WORD.
  - Registers lo = mem_data_out.
  - Next state: RESP.
- RESP, misaligned load:
  - Concatenate {mem_data_out, lo} into 64 bits.
  - Take `size` bytes starting at byte `off`.
  - Zero- or sign-extend to 32 bits per the latched sign bit.
- WR_BYTE:
  - mem_addr = (addr + k) mod 2^ADDR_WIDTH, BYTE, mem_write_enable=1, mem_data_in = {24'b0, wdata[8k+7:8k]}.
  - k increments each cycle; when k == size-1 the next state is RESP.
- RESP (1 cycle):
  - rsp_valid=1; req_ready=0; next state IDLE.
- Latency from the accepting edge to rsp_valid:
  - aligned access: 2 cycles;
  - misaligned load: 3 cycles;
  - misaligned store: size+1 cycles.
- Outside ALIGNED and WR_BYTE: mem_write_enable=0, and mem_addr holds its last value.
- Throughput: at most one request in flight. A request cannot be accepted in the RESP cycle; the next is accepted in the following IDLE cycle.
- Upstream rule: req_* may change while req_ready=0; only the handshake-edge values are used.

Decomposition:
- mem_pkg:
  - Reuse mem_width_t and WORD/HALFWORD/BYTE.
  - Add lsu_state_t (the six states).
  - Add function width_bytes(mem_width_t) returning 1/2/4.
- Sub-module lsu_align_merge (combinational):
  - inputs: lo, hi, off, width, sign_extend;
  - output: 32-bit extracted and extended word;
  - testable standalone.

Test Plan:
- Bench memory model preloaded with byte[i]=i.
- Aligned WORD load at 0 -> one mem read, mem_width=WORD; rsp_valid exactly 2 cycles after accept; rsp_rdata=0x03020100.
- Misaligned WORD load at 1 -> two reads at 0 then 4; rsp_rdata=0x04030201 after 3 cycles.
- Preload byte5=0x80, byte6=0xFF. HALFWORD load at 5: sign_extend=1 -> 0xFFFFFF80; sign_extend=0 -> 0x0000FF80.
- Misaligned WORD store 0xBAD01928 at 3 -> BYTE writes: 3←0x28, 4←0x19, 5←0xD0, 6←0xBA on consecutive cycles. Ack at cycle 5. A following WORD load at 3 returns 0xBAD01928.
- Wrap case: WORD load at 2^ADDR_WIDTH-2 -> second read at address 0. Upper two bytes come from bytes 0,1.
- Reset asserted during the second WR_BYTE cycle -> mem_write_enable=0 in that cycle; no rsp_valid; only the first byte is modified; req_ready=1 in the first cycle after reset deasserts.
